// File: rtl/mem_store_unit_if.sv
// Store-request handshake plus byte-wide RAM write port of the store unit.
// The slave modport is the unit's view; master is the MEM stage / arbiter / RAM side.
interface mem_store_unit_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [1:0]        st_size;
  logic              st_done;
  logic              busy;
  logic              bus_req;
  logic              bus_grant;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_we;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, bus_grant,
    output st_ready, st_done, busy, bus_req, ram_addr, ram_dout, ram_we
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, bus_grant,
    input  st_ready, st_done, busy, bus_req, ram_addr, ram_dout, ram_we
  );
endinterface

// File: rtl/mem_store_unit.sv
// Serialises a byte/half/word store onto the shared byte-wide RAM port,
// least-significant byte first, writing only while the arbiter grants the port.
module mem_store_unit #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  mem_store_unit_if.slave  sif
);

  typedef enum logic [1:0] {IDLE, REQ, WR, DONE} state_t;

  state_t            state;
  logic [1:0]        idx;
  logic [1:0]        last_idx;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_data;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dout_q;
  logic              ready_q;
  logic              done_q;
  logic              busy_q;
  logic              req_q;

  logic [1:0]        next_idx;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        next_byte;

  // Address/data of the byte after the current one; the sum wraps at 2^ADDR_W.
  assign next_idx  = idx + 2'd1;
  assign next_addr = held_addr + ADDR_W'(next_idx);
  assign next_byte = held_data[{next_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      last_idx  <= 2'd0;
      held_addr <= '0;
      held_data <= '0;
      addr_q    <= '0;
      dout_q    <= 8'd0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sif.st_valid && sif.st_size != 2'b00) begin
            held_addr <= sif.st_addr;
            held_data <= sif.st_data;
            case (sif.st_size)
              2'b01:   last_idx <= 2'd0;
              2'b10:   last_idx <= 2'd1;
              default: last_idx <= 2'd3;
            endcase
            state   <= REQ;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (sif.bus_grant) begin
            state  <= WR;
            idx    <= 2'd0;
            addr_q <= held_addr;
            dout_q <= held_data[7:0];
          end
        end
        WR: begin
          // Without grant the current byte stays presented and is rewritten later.
          if (sif.bus_grant) begin
            if (idx == last_idx) begin
              state  <= DONE;
              idx    <= 2'd0;
              addr_q <= '0;
              dout_q <= 8'd0;
              req_q  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx    <= next_idx;
              addr_q <= next_addr;
              dout_q <= next_byte;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign sif.st_ready = ready_q;
  assign sif.st_done  = done_q;
  assign sif.busy     = busy_q;
  assign sif.bus_req  = req_q;
  assign sif.ram_addr = addr_q;
  assign sif.ram_dout = dout_q;
  // Write strobe follows grant directly so a dropped grant suppresses the write at once.
  assign sif.ram_we   = (state == WR) && sif.bus_grant;

endmodule

// File: tb/tb_mem_store_unit.sv
// Scoreboard bench for mem_store_unit: expected RAM writes are queued at issue
// time and a negedge monitor pops and compares every ram_we cycle.
module tb_mem_store_unit;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_store_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

  mem_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks      = 0;
  int  errors      = 0;
  int  done_seen   = 0;
  int  done_exp    = 0;
  int  writes_seen = 0;
  int  writes_exp  = 0;
  int  waited, waited2, ready_at, done_at;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushBytes(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input int n);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = addr + ADDR_W'(k);
      e.data = data[8*k +: 8];
      exp_q.push_back(e);
    end
    writes_exp += n;
  endtask

  // Caller invokes this just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input bit push, output int edges);
    bit rdy;
    bit accepted;
    sif.st_addr  = addr;
    sif.st_data  = data;
    sif.st_size  = size;
    sif.st_valid = 1'b1;
    if (push) pushBytes(addr, data, (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4);
    edges    = 0;
    accepted = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rdy = sif.st_ready;
      @(posedge clk);
      edges++;
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept expected st_ready within 100 cycles");
    end
    #1 sif.st_valid = 1'b0;
  endtask

  // Counts falling edges until st_ready, noting which one carried st_done.
  task automatic measureReady(output int r_at, output int d_at);
    r_at = -1;
    d_at = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (sif.st_done === 1'b1) d_at = k;
      if (sif.st_ready === 1'b1) begin
        r_at = k;
        break;
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"},    sif.st_ready, 1);
    checkOutput({tag, "_done"},     sif.st_done,  0);
    checkOutput({tag, "_busy"},     sif.busy,     0);
    checkOutput({tag, "_bus_req"},  sif.bus_req,  0);
    checkOutput({tag, "_ram_we"},   sif.ram_we,   0);
    checkOutput({tag, "_ram_addr"}, sif.ram_addr, 0);
    checkOutput({tag, "_ram_dout"}, sif.ram_dout, 0);
  endtask

  // Monitor: every RAM write must match the next queued byte.
  always @(negedge clk) begin
    if (sif.st_done === 1'b1) done_seen++;
    if (sif.ram_we === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 sif.ram_addr, sif.ram_dout);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", sif.ram_addr, mon_e.addr);
        checkOutput("wr_data", sif.ram_dout, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sif.st_valid  = 1'b0;
    sif.st_addr   = '0;
    sif.st_data   = '0;
    sif.st_size   = 2'b00;
    sif.bus_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkResetOutputs("reset");
    rst           = 1'b1;
    sif.bus_grant = 1'b1;
    @(posedge clk) #1;

    // Byte store
    applyStimulus(17'h00100, 32'hAABBCCDD, 2'b01, 1'b1, waited);
    done_exp++;
    measureReady(ready_at, done_at);
    checkOutput("byte_done_at", done_at, 3);
    checkOutput("byte_ready_at", ready_at, 4);

    // Word store
    @(posedge clk) #1;
    applyStimulus(17'h00200, 32'h11223344, 2'b11, 1'b1, waited);
    done_exp++;
    measureReady(ready_at, done_at);
    checkOutput("word_done_at", done_at, 6);
    checkOutput("word_ready_at", ready_at, 7);

    // Grant stall between the two bytes of a half store
    @(posedge clk) #1;
    applyStimulus(17'h00010, 32'h0000BEEF, 2'b10, 1'b1, waited);
    done_exp++;
    @(posedge clk);
    @(posedge clk) #1 sif.bus_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_we", sif.ram_we, 0);
      checkOutput("stall_dout", sif.ram_dout, 8'hBE);
      checkOutput("stall_addr", sif.ram_addr, 17'h00011);
      checkOutput("stall_req", sif.bus_req, 1);
      @(posedge clk);
    end
    #1 sif.bus_grant = 1'b1;
    measureReady(ready_at, done_at);
    checkOutput("stall_done_at", done_at, 2);
    checkOutput("stall_ready_at", ready_at, 3);

    // Word store across the top of the address space
    @(posedge clk) #1;
    applyStimulus(17'h1FFFE, 32'h76543210, 2'b11, 1'b1, waited);
    done_exp++;
    measureReady(ready_at, done_at);
    checkOutput("wrap_ready_at", ready_at, 7);

    // No-op request is dropped
    @(posedge clk) #1;
    sif.st_addr  = 17'h00055;
    sif.st_data  = 32'h12345678;
    sif.st_size  = 2'b00;
    sif.st_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("noop_ready", sif.st_ready, 1);
    checkOutput("noop_busy", sif.busy, 0);
    checkOutput("noop_req", sif.bus_req, 0);
    checkOutput("noop_done_count", done_seen, done_exp);
    @(posedge clk) #1 sif.st_valid = 1'b0;

    // Reset in the middle of a word store, after two bytes
    @(posedge clk) #1;
    pushBytes(17'h00300, 32'hCAFEF00D, 2);
    applyStimulus(17'h00300, 32'hCAFEF00D, 2'b11, 1'b0, waited);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 checkResetOutputs("abort");
    @(posedge clk);
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1;
    applyStimulus(17'h00400, 32'h0000005A, 2'b01, 1'b1, waited);
    done_exp++;
    measureReady(ready_at, done_at);
    checkOutput("after_reset_ready_at", ready_at, 4);

    // Back-to-back word stores with st_valid held
    @(posedge clk) #1;
    applyStimulus(17'h00500, 32'h01020304, 2'b11, 1'b1, waited);
    applyStimulus(17'h00600, 32'hA0B0C0D0, 2'b11, 1'b1, waited2);
    done_exp += 2;
    checkOutput("b2b_accept_gap", waited2, 7);
    measureReady(ready_at, done_at);
    checkOutput("b2b_ready_at", ready_at, 7);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_count", done_seen, done_exp);
    checkOutput("write_count", writes_seen, writes_exp);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
